// File: rtl/pulse_capture.sv
// -----------------------------------------------------------------------------
// pulse_capture
//
// Measures a pulse train on a single input and reports it in the pulse
// generator's own field encoding: delay, pulse width, pulse count and pulse
// spacing. One capture runs per accepted arm. Results stay on the outputs
// until the next accepted arm.
//
// Ports:
//   clk             in   system clock
//   rst             in   synchronous active-high reset; aborts any capture
//   arm             in   start a capture (accepted only while ready_o = 1)
//   sig_i           in   signal under measurement
//   timeout_i[15:0] in   idle-low limit in cycles that ends a capture
//   delay_o[15:0]   out  cycles from arm to the first rising edge
//   pulse_width_o[7:0]    out  high cycles of the first pulse minus 1
//   num_pulses_o[7:0]     out  rising edges seen, saturating at 255
//   pulse_spacing_o[15:0] out  low cycles of the first gap minus 1
//   ready_o         out  idle; an arm is accepted
//   valid_o         out  one-cycle strobe when results are updated
//   timeout_o       out  the last capture saw no rising edge
//   overflow_o      out  a width, count or spacing value saturated
//
// Build option:
//   PULSE_CAPTURE_SYNC_EN  when defined, sig_i passes through a two-flop
//                          synchroniser ahead of the sample register, so the
//                          input-to-decision latency grows from 2 to 4 cycles.
//                          Required for asynchronous external triggers.
// -----------------------------------------------------------------------------
module pulse_capture (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        sig_i,
  input  logic [15:0] timeout_i,
  output logic [15:0] delay_o,
  output logic [7:0]  pulse_width_o,
  output logic [7:0]  num_pulses_o,
  output logic [15:0] pulse_spacing_o,
  output logic        ready_o,
  output logic        valid_o,
  output logic        timeout_o,
  output logic        overflow_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        samp_in_s;
  logic        s_r, s_d_r;
  logic        rise_s;
  logic [15:0] cnt_r, cnt_nxt_s;
  logic [7:0]  wcnt_r, wcnt_nxt_s;
  logic [15:0] scnt_r, scnt_nxt_s;
  logic [15:0] delay_r, delay_nxt_s;
  logic [7:0]  width_r, width_nxt_s;
  logic [7:0]  num_r, num_nxt_s;
  logic [15:0] spacing_r, spacing_nxt_s;
  logic        ready_r, ready_nxt_s;
  logic        valid_r, valid_nxt_s;
  logic        timeout_r, timeout_nxt_s;
  logic        overflow_r, overflow_nxt_s;

`ifdef PULSE_CAPTURE_SYNC_EN
  logic sync1_r, sync2_r;

  // Two-flop synchroniser for an asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= sig_i;
      sync2_r <= sync1_r;
    end
  end

  assign samp_in_s = sync2_r;
`else
  assign samp_in_s = sig_i;
`endif

  // Sample register and its one-cycle delayed copy used for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r   <= 1'b0;
      s_d_r <= 1'b0;
    end else begin
      s_r   <= samp_in_s;
      s_d_r <= s_r;
    end
  end

  assign rise_s = s_r & ~s_d_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-result logic; every register holds unless changed
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    wcnt_nxt_s     = wcnt_r;
    scnt_nxt_s     = scnt_r;
    delay_nxt_s    = delay_r;
    width_nxt_s    = width_r;
    num_nxt_s      = num_r;
    spacing_nxt_s  = spacing_r;
    ready_nxt_s    = ready_r;
    valid_nxt_s    = 1'b0;
    timeout_nxt_s  = timeout_r;
    overflow_nxt_s = overflow_r;

    case (state_r)
      ST_IDLE: begin
        if (arm) begin
          delay_nxt_s    = 16'd0;
          width_nxt_s    = 8'd0;
          num_nxt_s      = 8'd0;
          spacing_nxt_s  = 16'd0;
          timeout_nxt_s  = 1'b0;
          overflow_nxt_s = 1'b0;
          cnt_nxt_s      = 16'd0;
          ready_nxt_s    = 1'b0;
          state_nxt_s    = ST_WAIT;
        end else begin
          ready_nxt_s    = 1'b1;
        end
      end

      // A level that was already high at arm is not a pulse: only a true
      // low-to-high transition of the sample starts the measurement.
      ST_WAIT: begin
        if (rise_s) begin
          delay_nxt_s   = cnt_r;
          num_nxt_s     = 8'd1;
          wcnt_nxt_s    = 8'd0;
          state_nxt_s   = ST_HIGH;
        end else if (cnt_r == timeout_i) begin
          timeout_nxt_s = 1'b1;
          delay_nxt_s   = 16'd0;
          valid_nxt_s   = 1'b1;
          ready_nxt_s   = 1'b1;
          state_nxt_s   = ST_IDLE;
        end else begin
          cnt_nxt_s     = cnt_r + 16'd1;
        end
      end

      // No timeout here: a stuck-high input is only left through rst.
      ST_HIGH: begin
        if (s_r) begin
          if (wcnt_r == 8'hFF) begin
            overflow_nxt_s = 1'b1;
          end else begin
            wcnt_nxt_s     = wcnt_r + 8'd1;
          end
        end else begin
          // num_r is still 1 only while the first pulse is being measured
          if (num_r == 8'd1) begin
            width_nxt_s = wcnt_r;
          end else begin
            width_nxt_s = width_r;
          end
          scnt_nxt_s  = 16'd0;
          state_nxt_s = ST_LOW;
        end
      end

      ST_LOW: begin
        if (s_r) begin
          if (num_r == 8'd1) begin
            spacing_nxt_s = scnt_r;
          end else begin
            spacing_nxt_s = spacing_r;
          end
          if (num_r == 8'hFF) begin
            overflow_nxt_s = 1'b1;
          end else begin
            num_nxt_s      = num_r + 8'd1;
          end
          wcnt_nxt_s  = 8'd0;
          state_nxt_s = ST_HIGH;
        end else if (scnt_r == timeout_i) begin
          valid_nxt_s = 1'b1;
          ready_nxt_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          if (scnt_r == 16'hFFFF) begin
            overflow_nxt_s = 1'b1;
          end else begin
            scnt_nxt_s     = scnt_r + 16'd1;
          end
        end
      end

      default: begin
        ready_nxt_s = 1'b1;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Counters, result and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= 16'd0;
      wcnt_r     <= 8'd0;
      scnt_r     <= 16'd0;
      delay_r    <= 16'd0;
      width_r    <= 8'd0;
      num_r      <= 8'd0;
      spacing_r  <= 16'd0;
      ready_r    <= 1'b1;
      valid_r    <= 1'b0;
      timeout_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      wcnt_r     <= wcnt_nxt_s;
      scnt_r     <= scnt_nxt_s;
      delay_r    <= delay_nxt_s;
      width_r    <= width_nxt_s;
      num_r      <= num_nxt_s;
      spacing_r  <= spacing_nxt_s;
      ready_r    <= ready_nxt_s;
      valid_r    <= valid_nxt_s;
      timeout_r  <= timeout_nxt_s;
      overflow_r <= overflow_nxt_s;
    end
  end

  assign delay_o         = delay_r;
  assign pulse_width_o   = width_r;
  assign num_pulses_o    = num_r;
  assign pulse_spacing_o = spacing_r;
  assign ready_o         = ready_r;
  assign valid_o         = valid_r;
  assign timeout_o       = timeout_r;
  assign overflow_o      = overflow_r;

endmodule

// File: tb/tb_pulse_capture.sv
// -----------------------------------------------------------------------------
// tb_pulse_capture
//
// Self-checking bench for pulse_capture. Each input waveform is described
// cycle by cycle relative to the arm cycle (cycle 0 = cycle in which arm is
// driven). Expected results come from a run-length model of the waveform.
// -----------------------------------------------------------------------------
module tb_pulse_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        sig_i;
  logic [15:0] timeout_i;
  logic [15:0] delay_o;
  logic [7:0]  pulse_width_o;
  logic [7:0]  num_pulses_o;
  logic [15:0] pulse_spacing_o;
  logic        ready_o;
  logic        valid_o;
  logic        timeout_o;
  logic        overflow_o;

`ifdef PULSE_CAPTURE_SYNC_EN
  localparam int P = 3;   // input register stages before the sample s
`else
  localparam int P = 1;
`endif

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic wave [0:4095];
  int   wave_len = 0;
  int   exp_delay, exp_width, exp_num, exp_spacing, exp_to, exp_ovf, exp_vcyc;
  int   obs_vcnt, obs_vcyc;

  pulse_capture dut (
    .clk             (clk),
    .rst             (rst),
    .arm             (arm),
    .sig_i           (sig_i),
    .timeout_i       (timeout_i),
    .delay_o         (delay_o),
    .pulse_width_o   (pulse_width_o),
    .num_pulses_o    (num_pulses_o),
    .pulse_spacing_o (pulse_spacing_o),
    .ready_o         (ready_o),
    .valid_o         (valid_o),
    .timeout_o       (timeout_o),
    .overflow_o      (overflow_o)
  );

  always #5 clk = ~clk;

  // Input level in waveform cycle i; before cycle 0 the level is pre.
  function automatic logic wv(input int i, input logic pre);
    if (i < 0) return pre;
    else if (i < wave_len) return wave[i];
    else return 1'b0;
  endfunction

  // Run-length model: first rise inside the arm window, then alternate
  // high and low runs until a low run reaches tmo+2 cycles.
  task automatic model(input logic pre, input int tmo);
    int r, idx, h, g, n;
    r = -1;
    exp_delay = 0; exp_width = 0; exp_num = 0; exp_spacing = 0;
    exp_to = 0; exp_ovf = 0; exp_vcyc = 0;
    for (int k = 0; k <= tmo + 1 - P; k++) begin
      if (wv(k, pre) && !wv(k - 1, pre)) begin
        r = k;
        break;
      end
    end
    if (r < 0) begin
      exp_to   = 1;
      exp_vcyc = tmo + 2;
    end else begin
      exp_delay = r + P - 1;
      idx = r;
      n = 0;
      while (1'b1) begin
        h = 0;
        while (wv(idx, pre)) begin h++; idx++; end
        n++;
        if (n > 255) exp_ovf = 1; else exp_num = n;
        if (h - 1 > 255) exp_ovf = 1;
        if (n == 1) exp_width = (h - 1 > 255) ? 255 : h - 1;
        g = 0;
        while (!wv(idx, pre) && g < tmo + 2) begin g++; idx++; end
        if (g >= tmo + 2) begin
          exp_vcyc = idx - g + tmo + 2 + P;
          break;
        end
        if (n == 1) exp_spacing = g - 1;
      end
    end
  endtask

  // Drive the stored waveform with arm held for arm_len cycles from cycle 0,
  // recording how often and first when valid_o is seen.
  task automatic apply_wave(input logic pre, input int tmo, input int arm_len, input int n_cyc);
    timeout_i = 16'(tmo);
    sig_i = pre;
    arm = 1'b0;
    repeat (6) @(negedge clk);
    obs_vcnt = 0;
    obs_vcyc = -1;
    for (int j = 0; j < n_cyc; j++) begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        obs_vcnt++;
        if (obs_vcyc < 0) obs_vcyc = j;
      end
      sig_i = wv(j, pre);
      arm = (j < arm_len);
    end
    arm = 1'b0;
    sig_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; arm = 1'b0; sig_i = 1'b0; timeout_i = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b expected 1", ready_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", valid_o); end
    n_cmp++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %0b expected 0", timeout_o); end
    n_cmp++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0b expected 0", overflow_o); end
    n_cmp++; if (delay_o !== 16'd0) begin n_fail++; $display("FAIL rst_delay: got %0d expected 0", delay_o); end
    n_cmp++; if (pulse_width_o !== 8'd0) begin n_fail++; $display("FAIL rst_width: got %0d expected 0", pulse_width_o); end
    n_cmp++; if (num_pulses_o !== 8'd0) begin n_fail++; $display("FAIL rst_num: got %0d expected 0", num_pulses_o); end
    n_cmp++; if (pulse_spacing_o !== 16'd0) begin n_fail++; $display("FAIL rst_spacing: got %0d expected 0", pulse_spacing_o); end
  endtask

  // Generator D=10 W=3 N=3 S=5 enabled with arm: first rise in cycle D+2,
  // each pulse W+1 cycles high and each gap S+1 cycles low.
  task automatic test_loopback();
    int len;
    len = 0;
    for (int k = 0; k < 12; k++) begin wave[len] = 1'b0; len++; end
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin wave[len] = 1'b1; len++; end
      for (int k = 0; k < 6; k++) begin wave[len] = 1'b0; len++; end
    end
    wave_len = len;
    apply_wave(1'b0, 20, 1, 80);
    n_cmp++; if (obs_vcnt != 1) begin n_fail++; $display("FAIL loop_valid_count: got %0d expected 1", obs_vcnt); end
    n_cmp++; if (delay_o !== 16'(11 + P)) begin n_fail++; $display("FAIL loop_delay: got %0d expected %0d", delay_o, 11 + P); end
    n_cmp++; if (pulse_width_o !== 8'd3) begin n_fail++; $display("FAIL loop_width: got %0d expected 3", pulse_width_o); end
    n_cmp++; if (num_pulses_o !== 8'd3) begin n_fail++; $display("FAIL loop_num: got %0d expected 3", num_pulses_o); end
    n_cmp++; if (pulse_spacing_o !== 16'd5) begin n_fail++; $display("FAIL loop_spacing: got %0d expected 5", pulse_spacing_o); end
    n_cmp++; if (timeout_o !== 1'b0 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL loop_flags: got to=%0b ovf=%0b expected 0 0", timeout_o, overflow_o); end
  endtask

  task automatic test_wait_timeout();
    wave_len = 0;
    apply_wave(1'b0, 20, 1, 30);
    n_cmp++; if (obs_vcnt != 1 || obs_vcyc != 22) begin n_fail++; $display("FAIL tmo_valid: got count=%0d cycle=%0d expected 1 at 22", obs_vcnt, obs_vcyc); end
    n_cmp++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %0b expected 1", timeout_o); end
    n_cmp++; if (num_pulses_o !== 8'd0) begin n_fail++; $display("FAIL tmo_num: got %0d expected 0", num_pulses_o); end
    n_cmp++; if (delay_o !== 16'd0) begin n_fail++; $display("FAIL tmo_delay: got %0d expected 0", delay_o); end
  endtask

  task automatic test_high_at_arm();
    for (int k = 0; k < 15; k++) wave[k] = (k < 5 || k >= 12) ? 1'b1 : 1'b0;
    wave_len = 15;
    apply_wave(1'b1, 50, 1, 80);
    n_cmp++; if (obs_vcnt != 1) begin n_fail++; $display("FAIL harm_valid_count: got %0d expected 1", obs_vcnt); end
    n_cmp++; if (num_pulses_o !== 8'd1) begin n_fail++; $display("FAIL harm_num: got %0d expected 1", num_pulses_o); end
    n_cmp++; if (pulse_spacing_o !== 16'd0) begin n_fail++; $display("FAIL harm_spacing: got %0d expected 0", pulse_spacing_o); end
    n_cmp++; if (delay_o !== 16'(11 + P)) begin n_fail++; $display("FAIL harm_delay: got %0d expected %0d", delay_o, 11 + P); end
    n_cmp++; if (pulse_width_o !== 8'd2) begin n_fail++; $display("FAIL harm_width: got %0d expected 2", pulse_width_o); end
  endtask

  task automatic test_width_sat();
    for (int k = 0; k < 303; k++) wave[k] = (k >= 3) ? 1'b1 : 1'b0;
    wave_len = 303;
    apply_wave(1'b0, 10, 1, 330);
    n_cmp++; if (obs_vcnt != 1) begin n_fail++; $display("FAIL wsat_valid_count: got %0d expected 1", obs_vcnt); end
    n_cmp++; if (pulse_width_o !== 8'd255) begin n_fail++; $display("FAIL wsat_width: got %0d expected 255", pulse_width_o); end
    n_cmp++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL wsat_overflow: got %0b expected 1", overflow_o); end
    n_cmp++; if (num_pulses_o !== 8'd1) begin n_fail++; $display("FAIL wsat_num: got %0d expected 1", num_pulses_o); end
  endtask

  task automatic test_reset_mid_pulse();
    int vcnt;
    for (int k = 0; k < 42; k++) wave[k] = (k >= 2) ? 1'b1 : 1'b0;
    wave_len = 42;
    apply_wave(1'b0, 10, 1, 20);
    n_cmp++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got ready=%0b expected 0", ready_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %0b expected 1", ready_o); end
    n_cmp++; if (delay_o !== 16'd0 || num_pulses_o !== 8'd0 || pulse_width_o !== 8'd0)
      begin n_fail++; $display("FAIL rmid_results: got delay=%0d num=%0d width=%0d expected 0 0 0", delay_o, num_pulses_o, pulse_width_o); end
    vcnt = 0;
    for (int j = 0; j < 30; j++) begin
      if (valid_o === 1'b1) vcnt++;
      @(negedge clk);
    end
    n_cmp++; if (vcnt != 0) begin n_fail++; $display("FAIL rmid_no_valid: got %0d strobes expected 0", vcnt); end
  endtask

  task automatic test_arm_busy();
    for (int k = 0; k < 13; k++) wave[k] = ((k >= 5 && k < 8) || k >= 10) ? 1'b1 : 1'b0;
    wave_len = 13;
    model(1'b0, 6);
    apply_wave(1'b0, 6, 12, exp_vcyc + 6);
    n_cmp++; if (obs_vcnt != 1 || obs_vcyc != exp_vcyc) begin n_fail++; $display("FAIL busy_valid: got count=%0d cycle=%0d expected 1 at %0d", obs_vcnt, obs_vcyc, exp_vcyc); end
    n_cmp++; if (delay_o !== 16'(exp_delay)) begin n_fail++; $display("FAIL busy_delay: got %0d expected %0d", delay_o, exp_delay); end
    n_cmp++; if (num_pulses_o !== 8'(exp_num)) begin n_fail++; $display("FAIL busy_num: got %0d expected %0d", num_pulses_o, exp_num); end
  endtask

  task automatic test_count_sat();
    wave[0] = 1'b0;
    wave[1] = 1'b0;
    for (int k = 0; k < 520; k++) wave[k + 2] = (k % 2 == 0) ? 1'b1 : 1'b0;
    wave_len = 522;
    apply_wave(1'b0, 4, 1, 540);
    n_cmp++; if (obs_vcnt != 1) begin n_fail++; $display("FAIL csat_valid_count: got %0d expected 1", obs_vcnt); end
    n_cmp++; if (num_pulses_o !== 8'd255) begin n_fail++; $display("FAIL csat_num: got %0d expected 255", num_pulses_o); end
    n_cmp++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL csat_overflow: got %0b expected 1", overflow_o); end
    n_cmp++; if (pulse_spacing_o !== 16'd0) begin n_fail++; $display("FAIL csat_spacing: got %0d expected 0", pulse_spacing_o); end
    n_cmp++; if (pulse_width_o !== 8'd0) begin n_fail++; $display("FAIL csat_width: got %0d expected 0", pulse_width_o); end
  endtask

  // Second arm presented in the valid cycle of the first capture.
  task automatic test_back_to_back();
    int vcnt, v1, v2;
    logic rdy5;
    timeout_i = 16'd3; sig_i = 1'b0; arm = 1'b0;
    repeat (6) @(negedge clk);
    vcnt = 0; v1 = -1; v2 = -1; rdy5 = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        vcnt++;
        if (v1 < 0) v1 = j; else if (v2 < 0) v2 = j;
      end
      if (j == 5) rdy5 = ready_o;
      arm = (j == 0 || j == 5);
    end
    arm = 1'b0;
    n_cmp++; if (vcnt != 2 || v1 != 5 || v2 != 10) begin n_fail++; $display("FAIL b2b_valid: got count=%0d at %0d,%0d expected 2 at 5,10", vcnt, v1, v2); end
    n_cmp++; if (rdy5 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %0b expected 1", rdy5); end
  endtask

  task automatic test_random();
    int tmo, len, np, h, g, ld;
    logic pre;
    for (int it = 0; it < 30; it++) begin
      tmo = $urandom_range(2, 10);
      pre = 1'($urandom_range(0, 1));
      len = 0;
      if (pre) begin
        h = $urandom_range(0, 3);
        for (int k = 0; k < h; k++) begin wave[len] = 1'b1; len++; end
      end
      ld = $urandom_range(1, tmo + 6);
      for (int k = 0; k < ld; k++) begin wave[len] = 1'b0; len++; end
      np = $urandom_range(1, 4);
      for (int p = 0; p < np; p++) begin
        h = $urandom_range(1, 6);
        for (int k = 0; k < h; k++) begin wave[len] = 1'b1; len++; end
        if (p < np - 1) begin
          g = $urandom_range(1, tmo + 3);
          for (int k = 0; k < g; k++) begin wave[len] = 1'b0; len++; end
        end
      end
      wave_len = len;
      model(pre, tmo);
      apply_wave(pre, tmo, 1, exp_vcyc + 6);
      n_cmp++; if (obs_vcnt != 1 || obs_vcyc != exp_vcyc) begin n_fail++; $display("FAIL rnd%0d_valid: got count=%0d cycle=%0d expected 1 at %0d", it, obs_vcnt, obs_vcyc, exp_vcyc); end
      n_cmp++; if (delay_o !== 16'(exp_delay)) begin n_fail++; $display("FAIL rnd%0d_delay: got %0d expected %0d", it, delay_o, exp_delay); end
      n_cmp++; if (pulse_width_o !== 8'(exp_width)) begin n_fail++; $display("FAIL rnd%0d_width: got %0d expected %0d", it, pulse_width_o, exp_width); end
      n_cmp++; if (num_pulses_o !== 8'(exp_num)) begin n_fail++; $display("FAIL rnd%0d_num: got %0d expected %0d", it, num_pulses_o, exp_num); end
      n_cmp++; if (pulse_spacing_o !== 16'(exp_spacing)) begin n_fail++; $display("FAIL rnd%0d_spacing: got %0d expected %0d", it, pulse_spacing_o, exp_spacing); end
      n_cmp++; if (timeout_o !== 1'(exp_to)) begin n_fail++; $display("FAIL rnd%0d_timeout: got %0b expected %0d", it, timeout_o, exp_to); end
      n_cmp++; if (overflow_o !== 1'(exp_ovf)) begin n_fail++; $display("FAIL rnd%0d_overflow: got %0b expected %0d", it, overflow_o, exp_ovf); end
    end
  endtask

  initial begin
    rst = 1'b1;
    arm = 1'b0;
    sig_i = 1'b0;
    timeout_i = 16'd0;
    test_reset();
    test_loopback();
    test_wait_timeout();
    test_high_at_arm();
    test_width_sat();
    test_reset_mid_pulse();
    test_arm_busy();
    test_count_sat();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
